// File: rtl/vend_pkg.sv
// Shared coin/change codes and the sequencer state encoding for the vend_* blocks.
package vend_pkg;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_5    = 3'b001;
  localparam logic [2:0] COIN_10   = 3'b010;
  localparam logic [2:0] IDLE_CODE = 3'b011;

  localparam logic [2:0] CHG_NONE = 3'b000;
  localparam logic [2:0] CHG_5    = 3'b001;
  localparam logic [2:0] CHG_10   = 3'b010;
  localparam logic [2:0] CHG_15   = 3'b011;
  localparam logic [2:0] CHG_20   = 3'b100;

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, CANCEL, WAIT, DISPENSE} state_t;

  function automatic logic is_coin(input logic [2:0] code);
    return (code == COIN_5) || (code == COIN_10);
  endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Round-robin arbiter: grants the first request at/after the pointer; pointer moves past the winner on advance.
module vend_rr_arbiter #(
  parameter int N = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;

  // NOTE: every combinational output gets a default before the search loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                     = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        grant_idx                 = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Shares the vending core's coin input among NUM_REQ acceptors; drives dispense motor and refund pulse.
// Optional VEND_AUDIT_EN adds saturating vend_count and refund_total audit outputs.
module vend_sequencer #(
  parameter int NUM_REQ        = 2,
  parameter int RESP_LAT       = 2,
  parameter int DISP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   coin_req,
  input  logic [3*NUM_REQ-1:0] coin_code,
  input  logic                 cancel_req,
  output logic [NUM_REQ-1:0]   coin_ack,
  output logic [2:0]           core_in,
  input  logic                 core_out,
  input  logic [2:0]           core_change,
  output logic                 motor_on,
  output logic                 refund_valid,
  output logic [2:0]           refund_amt,
  output logic                 coin_err,
  output logic                 busy
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]          vend_count,
  output logic [15:0]          refund_total
`endif
);
  import vend_pkg::*;

  localparam int MAX_A = (RESP_LAT > DISP_CYCLES) ? RESP_LAT : DISP_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAX_P + 1);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_LAT - 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES - 1);

  state_t             state, state_d;
  logic [2:0]         code_q, code_d;
  logic [NUM_REQ-1:0] coin_ack_d;
  logic               coin_err_d, motor_on_d, refund_valid_d;
  logic [2:0]         core_in_d, refund_amt_d;
  logic               credit_q, credit_d, cancel_q, cancel_d, vend_q, vend_d, vend_now;
  logic [2:0]         chg_q, chg_d, chg_now;
  logic [CNT_W-1:0]   tmo_q, tmo_d, cnt_q, cnt_d;
  logic               adv;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  vend_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (coin_req),
    .advance   (adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_d        = state;
    code_d         = code_q;
    coin_ack_d     = '0;
    coin_err_d     = 1'b0;
    core_in_d      = IDLE_CODE;
    motor_on_d     = 1'b0;
    refund_valid_d = 1'b0;
    refund_amt_d   = refund_amt;
    credit_d       = credit_q;
    cancel_d       = cancel_q;
    vend_d         = vend_q;
    chg_d          = chg_q;
    tmo_d          = '0;
    cnt_d          = '0;
    adv            = 1'b0;
    vend_now       = vend_q | core_out;
    chg_now        = (core_change != CHG_NONE) ? core_change : chg_q;
    unique case (state)
      IDLE: begin
        // Cancel (user or timeout) takes priority over a coin arriving the same cycle.
        if (credit_q && (cancel_req || tmo_q == TMO_MAX)) begin
          state_d   = CANCEL;
          core_in_d = COIN_NONE;
          cancel_d  = 1'b1;
        end else if (|coin_req) begin
          state_d    = GRANT;
          adv        = 1'b1;
          coin_ack_d = grant;
          code_d     = coin_code[3*grant_idx +: 3];
          coin_err_d = !is_coin(coin_code[3*grant_idx +: 3]);
        end else if (credit_q) begin
          tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        end
      end
      GRANT: begin
        if (is_coin(code_q)) begin
          state_d   = ISSUE;
          core_in_d = code_q;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, CANCEL: begin
        if (state == ISSUE) credit_d = 1'b1;
        state_d = WAIT;
        vend_d  = 1'b0;
        chg_d   = CHG_NONE;
      end
      WAIT: begin
        vend_d = vend_now;
        chg_d  = chg_now;
        if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          if (vend_now) begin
            state_d    = DISPENSE;
            motor_on_d = 1'b1;
            credit_d   = 1'b0;
          end
          if (chg_now != CHG_NONE) begin
            refund_valid_d = 1'b1;
            refund_amt_d   = chg_now;
            credit_d       = 1'b0;
          end
          if (cancel_q) begin
            credit_d = 1'b0;
            cancel_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DISPENSE: begin
        if (cnt_q == DISP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          motor_on_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      code_q       <= COIN_NONE;
      coin_ack     <= '0;
      coin_err     <= 1'b0;
      core_in      <= IDLE_CODE;
      motor_on     <= 1'b0;
      refund_valid <= 1'b0;
      refund_amt   <= CHG_NONE;
      credit_q     <= 1'b0;
      cancel_q     <= 1'b0;
      vend_q       <= 1'b0;
      chg_q        <= CHG_NONE;
      tmo_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state        <= state_d;
      code_q       <= code_d;
      coin_ack     <= coin_ack_d;
      coin_err     <= coin_err_d;
      core_in      <= core_in_d;
      motor_on     <= motor_on_d;
      refund_valid <= refund_valid_d;
      refund_amt   <= refund_amt_d;
      credit_q     <= credit_d;
      cancel_q     <= cancel_d;
      vend_q       <= vend_d;
      chg_q        <= chg_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef VEND_AUDIT_EN
  logic [16:0] refund_sum;
  assign refund_sum = {1'b0, refund_total} + 17'(refund_amt) * 17'd5;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vend_count   <= '0;
      refund_total <= '0;
    end else begin
      if (state == WAIT && state_d == DISPENSE && vend_count != 16'hFFFF)
        vend_count <= vend_count + 16'd1;
      if (refund_valid)
        refund_total <= refund_sum[16] ? 16'hFFFF : refund_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer against a behavioural 25-cent vending core model.
// Build with VEND_AUDIT_EN defined to also connect the audit outputs.
module tb_vend_sequencer;
  import vend_pkg::*;

  localparam int NUM_REQ        = 2;
  localparam int RESP_LAT       = 2;
  localparam int DISP_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 1000;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   coin_req;
  logic [3*NUM_REQ-1:0] coin_code;
  logic                 cancel_req;
  logic [NUM_REQ-1:0]   coin_ack;
  logic [2:0]           core_in;
  logic                 core_out;
  logic [2:0]           core_change;
  logic                 motor_on;
  logic                 refund_valid;
  logic [2:0]           refund_amt;
  logic                 coin_err;
  logic                 busy;
`ifdef VEND_AUDIT_EN
  logic [15:0]          vend_count;
  logic [15:0]          refund_total;
`endif

  vend_sequencer #(
    .NUM_REQ(NUM_REQ), .RESP_LAT(RESP_LAT),
    .DISP_CYCLES(DISP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_req     (coin_req),
    .coin_code    (coin_code),
    .cancel_req   (cancel_req),
    .coin_ack     (coin_ack),
    .core_in      (core_in),
    .core_out     (core_out),
    .core_change  (core_change),
    .motor_on     (motor_on),
    .refund_valid (refund_valid),
    .refund_amt   (refund_amt),
    .coin_err     (coin_err),
    .busy         (busy)
`ifdef VEND_AUDIT_EN
    ,
    .vend_count   (vend_count),
    .refund_total (refund_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vending core: 5/10 credit, vends at >=25 with change, code 000 returns all credit.
  int vm_credit, vm_sum;
  always_comb begin
    vm_sum = vm_credit;
    if (core_in == COIN_5) vm_sum = vm_credit + 5;
    else if (core_in == COIN_10) vm_sum = vm_credit + 10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vm_credit   <= 0;
      core_out    <= 1'b0;
      core_change <= 3'b000;
    end else begin
      core_out    <= 1'b0;
      core_change <= 3'b000;
      if (is_coin(core_in)) begin
        if (vm_sum >= 25) begin
          core_out    <= 1'b1;
          core_change <= 3'((vm_sum - 25) / 5);
          vm_credit   <= 0;
        end else begin
          vm_credit <= vm_sum;
        end
      end else if (core_in == COIN_NONE) begin
        core_change <= 3'(vm_credit / 5);
        vm_credit   <= 0;
      end
    end
  end

  typedef enum int {EV_ACK, EV_CORE, EV_REFUND, EV_DISP} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       aux;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  t_issue = 0;
  int  t_cancel = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int v, input int a);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.aux  = a;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int v, input int a);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got val %0d aux %0d, required no event (t=%0t)", k.name(), v, a, $time);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(k), int'(e.kind));
      check($sformatf("%s_val", e.kind.name()), v, e.val);
      check($sformatf("%s_aux", e.kind.name()), a, e.aux);
    end
  endtask

  // Monitor: turns DUT outputs into events in a fixed per-cycle order (ack, core, refund, motor end).
  initial begin
    int mlen;
    mlen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mlen = 0;
      end else begin
        if (coin_ack != '0) begin
          check("ack_onehot", int'($onehot(coin_ack)), 1);
          observe(EV_ACK, int'(coin_ack), int'(coin_err));
        end else if (coin_err) begin
          observe(EV_ACK, 0, 1);
        end
        if (core_in != IDLE_CODE) begin
          if (core_in == COIN_NONE) t_cancel = cyc;
          else t_issue = cyc;
          observe(EV_CORE, int'(core_in), 0);
        end
        if (refund_valid) observe(EV_REFUND, int'(refund_amt), int'(motor_on));
        if (motor_on) begin
          mlen++;
        end else if (mlen != 0) begin
          observe(EV_DISP, mlen, 0);
          mlen = 0;
        end
      end
    end
  end

  task automatic send_coin(input int idx, input logic [2:0] code);
    bit got;
    got = 1'b0;
    coin_code[3*idx +: 3] = code;
    coin_req[idx] = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (coin_ack[idx]) got = 1'b1;
    end
    coin_req[idx] = 1'b0;
    if (!got) check($sformatf("ack_timeout_a%0d", idx), 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_refund(input int limit);
    bit got;
    got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (refund_valid) got = 1'b1;
    end
    if (!got) check("refund_timeout", 0, 1);
  endtask

  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    coin_req   = '0;
    cancel_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coin_ack"}, int'(coin_ack), 0);
    check({tag, "_core_in"}, int'(core_in), int'(IDLE_CODE));
    check({tag, "_motor_on"}, int'(motor_on), 0);
    check({tag, "_refund_valid"}, int'(refund_valid), 0);
    check({tag, "_refund_amt"}, int'(refund_amt), 0);
    check({tag, "_coin_err"}, int'(coin_err), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int acks;
    rst        = 1'b0;
    coin_req   = '0;
    coin_code  = '0;
    cancel_req = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: 10+10+5 from A0 vends exactly, no refund.
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 1, 0);
    expect_ev(EV_DISP, DISP_CYCLES, 0);
    send_coin(0, COIN_10);
    send_coin(0, COIN_10);
    send_coin(0, COIN_5);
    wait_idle();

    // 3: 10+10+10 vends with 5 change; refund coincides with motor start.
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_REFUND, 1, 1);
    expect_ev(EV_DISP, DISP_CYCLES, 0);
    send_coin(0, COIN_10);
    send_coin(0, COIN_10);
    send_coin(0, COIN_10);
    wait_idle();

    // 4: a lone 5 times out and is returned through code 000.
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 1, 0);
    expect_ev(EV_CORE, 0, 0); expect_ev(EV_REFUND, 1, 0);
    send_coin(0, COIN_5);
    wait_refund(TIMEOUT_CYCLES + 200);
    // Issue cycle, RESP_LAT wait cycles, IDLE while tmo runs 0..TIMEOUT_CYCLES, then CANCEL.
    check("timeout_gap", t_cancel - t_issue, 1 + RESP_LAT + TIMEOUT_CYCLES + 1);
    wait_idle();

    do_reset();

    // 2: both acceptors request 5s continuously; grants alternate from A0.
    for (int i = 0; i < 6; i++) begin
      expect_ev(EV_ACK, (i % 2 == 0) ? 1 : 2, 0);
      expect_ev(EV_CORE, 1, 0);
      if (i == 4) expect_ev(EV_DISP, DISP_CYCLES, 0);
    end
    expect_ev(EV_CORE, 0, 0);
    expect_ev(EV_REFUND, 1, 0);
    coin_code = {COIN_5, COIN_5};
    coin_req  = 2'b11;
    acks = 0;
    for (int k = 0; k < 400 && acks < 6; k++) begin
      @(negedge clk);
      if (coin_ack != '0) acks++;
    end
    coin_req = '0;
    check("rr_ack_count", acks, 6);
    cancel_req = 1'b1;
    wait_refund(50);
    cancel_req = 1'b0;
    wait_idle();

    // 5: cancel beats a simultaneous A1 request; A1's bad code then errors without core activity.
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_CORE, 0, 0); expect_ev(EV_REFUND, 2, 0);
    expect_ev(EV_ACK, 2, 1);
    send_coin(0, COIN_10);
    wait_idle();
    cancel_req = 1'b1;
    send_coin(1, 3'b111);
    cancel_req = 1'b0;
    @(negedge clk);
    check("err_core_in_idle", int'(core_in), int'(IDLE_CODE));
    wait_idle();

    do_reset();

    // 6: reset during dispense drops motor_on without waiting for a clock edge.
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 2, 0);
    expect_ev(EV_ACK, 1, 0); expect_ev(EV_CORE, 1, 0);
    send_coin(0, COIN_10);
    send_coin(0, COIN_10);
    send_coin(0, COIN_5);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (motor_on) seen = 1'b1;
      end
      check("motor_started", int'(seen), 1);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("queue_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
